// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and a single-port data memory.
// Queues stores, drains one per non-load cycle, and forwards pending data to loads.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    input  logic [AW-1:0]              st_addr,
    input  logic [DW-1:0]              st_data,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [AW-1:0]              ld_addr,
    output logic                       ld_hit,
    output logic [DW-1:0]              ld_data,
    output logic                       mem_write,
    output logic [AW-1:0]              mem_address,
    output logic [DW-1:0]              mem_write_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          enq;
    logic          drain;
    logic [DEPTH-1:0] match;

    assign empty    = (count_q == '0);
    assign st_ready = (count_q < CW'(DEPTH));
    assign enq      = st_valid && st_ready;
    assign drain    = !empty && !ld_valid;
    assign count    = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (drain) begin
            head_d = head_q + PW'(1);
        end
        if (enq) begin
            tail_d = tail_q + PW'(1);
        end
        if (enq && !drain) begin
            count_d = count_q + CW'(1);
        end else if (drain && !enq) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry contents need no reset: validity comes solely from head/count.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[tail_q] <= st_addr;
            data_mem[tail_q] <= st_data;
        end
    end

    assign mem_write      = drain;
    assign mem_address    = empty ? '0 : addr_mem[head_q];
    assign mem_write_data = empty ? '0 : data_mem[head_q];

    // match[gi] refers to the gi-th oldest entry, so higher index means younger.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = (CW'(gi) < count_q) &&
                               (addr_mem[head_q + PW'(gi)] == ld_addr);
        end
    endgenerate

    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (match[k]) begin
                ld_hit  = 1'b1;
                ld_data = data_mem[head_q + PW'(k)];
            end
        end
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Store buffer for the 16-bit pipelined CPU, sitting directly upstream of the data memory between the EX/MEM pipeline register and the memory write port. It queues stores in a small FIFO and drains them one per cycle into data memory whenever the memory is not servicing a load. The data memory has a single port, so a load and a write cannot share a cycle. It also forwards buffered store data to loads that hit a pending address, so loads never read stale memory.

## Interface

Parameters:
- DEPTH, 4, number of buffer entries; power of two, ≥ 2
- AW, 16, address width
- DW, 16, data width

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- st_valid  in  1  store request from MEM stage this cycle
- st_addr  in  AW  store address
- st_data  in  DW  store data
- st_ready  out  1  buffer can accept a store this cycle; MEM stage stalls when low
- ld_valid  in  1  load issued to data memory this cycle
- ld_addr  in  AW  load address
- ld_hit  out  1  a buffered entry matches ld_addr
- ld_data  out  DW  data of youngest matching entry; 0 when no hit
- mem_write  out  1  write strobe to data memory
- mem_address  out  AW  write address to data memory
- mem_write_data  out  DW  write data to data memory
- count  out  clog2(DEPTH)+1  number of valid entries
- empty  out  1  count == 0

## Operation

- Storage: circular FIFO of {addr, data} with head pointer (oldest), tail pointer (next free), and count. Pointers wrap modulo DEPTH.
- Enqueue:
  - Occurs when st_valid && st_ready. Entry is written at tail, and tail advances.
  - st_ready = (count < DEPTH). It does not depend on a same-cycle drain.
  - When st_valid && !st_ready, nothing is captured. The MEM stage holds st_addr/st_data until accepted.
- Drain:
  - drain = !empty && !ld_valid.
  - mem_write = drain.
  - mem_address and mem_write_data show the head entry combinationally whenever !empty. When empty they are 0.
  - Head advances on the edge where drain = 1.
  - Loads have priority; a drain is skipped in any cycle with ld_valid = 1.
- Count update:
  - Enqueue only: count + 1.
  - Drain only: count − 1.
  - Both in the same cycle: count unchanged.
  - Enqueue and drain may occur together at any count < DEPTH, including count = 0? No. Drain requires !empty, so a store into an empty buffer cannot drain in its enqueue cycle.
- Forwarding:
  - Combinational compare of ld_addr against all valid entries, using the full AW bits.
  - On multiple matches, the youngest (closest to tail) wins.
  - ld_hit / ld_data are valid regardless of ld_valid. The consumer uses them only when ld_valid = 1.
  - A store being presented on st_* in the same cycle is not forwarded. It is visible starting the next cycle.
  - The head entry remains a forwarding source until the edge that drains it.
- No coalescing: repeated stores to one address each occupy an entry and drain in order.
- Reset (async, rst_n low):
  - count = 0, head = tail = 0, all entries invalid.
  - mem_write = 0, mem_address = 0, mem_write_data = 0.
  - ld_hit = 0, ld_data = 0, st_ready = 1, empty = 1.
  - Pending stores are discarded.
  - Normal operation resumes on the first rising edge after rst_n goes high.

## Timing

- Store-to-memory latency:
  - Store accepted at edge N; mem_write = 1 during cycle N+1 if ld_valid = 0.
  - Data memory commits at edge N+1.
- Drain throughput: 1 entry/cycle. Each load cycle delays draining by one cycle.
- Forwarding latency: 0 cycles (combinational) for entries present in the buffer; 1 cycle after acceptance for a new store.
- st_ready is registered-state derived (from count). It has no combinational path from st_valid or ld_valid.
- mem_write depends combinationally on ld_valid. The upstream load decision must settle early in the cycle.
- Full boundary:
  - At count = DEPTH, st_ready = 0 even if a drain occurs that cycle.
  - st_ready returns to 1 the cycle after the first drain.

## Test plan

- Reset: assert rst_n = 0 mid-cycle → immediately count = 0, empty = 1, mem_write = 0, st_ready = 1, ld_hit = 0. Release rst_n; nothing drains.
- Single store: st 0x0010 = 0xBEEF, ld_valid = 0 → next cycle mem_write = 1, mem_address = 0x0010, mem_write_data = 0xBEEF for exactly one cycle; then empty = 1.
- Fill/backpressure: hold ld_valid = 1 and issue stores to 0x0001..0x0005 → count = 4, st_ready = 0, 5th store held. Drop ld_valid → writes 0x0001..0x0004 in order, one per cycle. 5th store accepted the cycle st_ready = 1 and written last.
- Forwarding: ld_valid = 1, store 0x0020 = 0x1111 then 0x0020 = 0x2222; ld_addr = 0x0020 → ld_hit = 1, ld_data = 0x2222. ld_addr = 0x0021 → ld_hit = 0, ld_data = 0.
- Simultaneous enqueue/drain: count = 2, ld_valid = 0, st_valid = 1 → count stays 2. FIFO order is preserved across pointer wrap over 3 × DEPTH stores.
- Reset mid-drain: 3 entries buffered, drain in progress, rst_n = 0 → mem_write drops without waiting for a clock. After release, count = 0 and no further writes occur.
